// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: forwarding-select encodings and
// the packed layout of one shadow-pipeline entry.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  // Entry layout: {waddr, load, wen, valid}, waddr occupies the top ASIZE bits.
  localparam int ENT_VALID    = 0;
  localparam int ENT_WEN      = 1;
  localparam int ENT_LOAD     = 2;
  localparam int ENT_ADDR_LSB = 3;
  localparam int ENT_CTRL_W   = 3;

  function automatic int ent_width(input int asize);
    return ENT_CTRL_W + asize;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage request / hazard-response bundle between the pipeline and hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int ASIZE = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             id_ren1;
  logic [ASIZE-1:0] id_raddr1;
  logic             id_ren2;
  logic [ASIZE-1:0] id_raddr2;
  logic             id_wen;
  logic [ASIZE-1:0] id_waddr;
  logic             id_load;
  logic             ex_taken;
  logic             stall;
  logic             flush;
  logic             bubble;
  logic [1:0]       ex_fwd_sel1;
  logic [1:0]       ex_fwd_sel2;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_ren1, id_raddr1, id_ren2, id_raddr2,
           id_wen, id_waddr, id_load, ex_taken,
    input  stall, flush, bubble, ex_fwd_sel1, ex_fwd_sel2, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_ren1, id_raddr1, id_ren2, id_raddr2,
           id_wen, id_waddr, id_load, ex_taken,
    output stall, flush, bubble, ex_fwd_sel1, ex_fwd_sel2, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; async active-low clear.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign cnt_d = inc_i ? sat_inc(cnt_q) : cnt_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock/forwarding controller for the ID/EXE/MEM/WB pipeline.
// Build option: define FORWARD_EN to enable operand forwarding; otherwise any in-flight match stalls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int ASIZE    = 4,
  parameter int NSTAGE   = 3,
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hif
);

  localparam int EW = ent_width(ASIZE);

  logic [EW-1:0]     ent_q [NSTAGE];
  logic [EW-1:0]     ent_d;
  logic [NSTAGE-1:0] m1, m2;
  logic              ren1, ren2;
  logic              haz, stall_c, flush_c, bubble_c;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  function automatic logic src_match(input logic ren, input logic [ASIZE-1:0] src,
                                     input logic [EW-1:0] e);
    logic zero_src;
    zero_src = (ZERO_REG != 0) && (src == '0);
    return ren && e[ENT_VALID] && e[ENT_WEN] &&
           (e[ENT_ADDR_LSB +: ASIZE] == src) && !zero_src;
  endfunction

  assign ren1 = hif.id_valid & hif.id_ren1;
  assign ren2 = hif.id_valid & hif.id_ren2;

  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      m1[k] = src_match(ren1, hif.id_raddr1, ent_q[k]);
      m2[k] = src_match(ren2, hif.id_raddr2, ent_q[k]);
    end
  end

`ifdef FORWARD_EN
  // WB has no write-through, and a load in EXE has no data yet: both must wait a cycle.
  assign haz = m1[2] | m2[2] | (ent_q[0][ENT_LOAD] & (m1[0] | m2[0]));
`else
  assign haz = |{m1, m2};
`endif

  // A taken branch discards the ID instruction, so its hazard no longer matters.
  assign flush_c  = hif.ex_taken & rst;
  assign stall_c  = haz & ~hif.ex_taken & rst;
  assign bubble_c = stall_c | flush_c;

  always_comb begin
    ent_d = '0;
    if (!bubble_c) begin
      ent_d[ENT_VALID]               = hif.id_valid;
      ent_d[ENT_WEN]                 = hif.id_wen;
      ent_d[ENT_LOAD]                = hif.id_load;
      ent_d[ENT_ADDR_LSB +: ASIZE]   = hif.id_waddr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NSTAGE; k++) ent_q[k] <= '0;
    end else begin
      ent_q[0] <= ent_d;
      for (int k = 1; k < NSTAGE; k++) ent_q[k] <= ent_q[k-1];
    end
  end

`ifdef FORWARD_EN
  logic [1:0] sel1_d, sel2_d, sel1_q, sel2_q;

  function automatic logic [1:0] pick_src(input logic hit_ex, input logic hit_mem);
    if (hit_ex)  return FWD_EXMEM;
    if (hit_mem) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  assign sel1_d = bubble_c ? FWD_RF : pick_src(m1[0], m1[1]);
  assign sel2_d = bubble_c ? FWD_RF : pick_src(m2[0], m2[1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel1_q <= FWD_RF;
      sel2_q <= FWD_RF;
    end else begin
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
    end
  end

  assign hif.ex_fwd_sel1 = sel1_q;
  assign hif.ex_fwd_sel2 = sel2_q;
`else
  assign hif.ex_fwd_sel1 = FWD_RF;
  assign hif.ex_fwd_sel2 = FWD_RF;
`endif

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst),
    .inc_i (stall_c),
    .cnt_o (stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst),
    .inc_i (flush_c),
    .cnt_o (flush_cnt)
  );

  assign hif.stall     = stall_c;
  assign hif.flush     = flush_c;
  assign hif.bubble    = bubble_c;
  assign hif.stall_cnt = stall_cnt;
  assign hif.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a reference model of in-flight writers predicts each cycle's outputs.
module tb_hazard_ctrl;

  localparam int AS = 4;
  localparam int CW = 4;
  localparam int ZR = 1;

  typedef struct packed {
    logic          v;
    logic          r1en;
    logic [AS-1:0] r1;
    logic          r2en;
    logic [AS-1:0] r2;
    logic          wen;
    logic [AS-1:0] wa;
    logic          ld;
  } ins_t;

  typedef struct packed {
    logic          stall;
    logic          flush;
    logic          bubble;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic clk;
  logic rst;
  hazard_ctrl_if #(.ASIZE(AS), .CNT_W(CW)) hif ();

  hazard_ctrl #(.ASIZE(AS), .NSTAGE(3), .CNT_W(CW), .ZERO_REG(ZR)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  // Model state: instructions that went past ID, youngest first (0=EXE, 1=MEM, 2=WB).
  ins_t          hist [3];
  logic [1:0]    m_s1, m_s2;
  logic [CW-1:0] m_sc, m_fc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic hit(input logic en, input logic [AS-1:0] src, input int k);
    if (!en) return 1'b0;
    if (ZR != 0 && src == 0) return 1'b0;
    return hist[k].v && hist[k].wen && (hist[k].wa == src);
  endfunction

  function automatic logic [1:0] fsel(input logic en, input logic [AS-1:0] src);
    if (hit(en, src, 0)) return 2'd1;
    if (hit(en, src, 1)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic ins_t mk(input logic v, input logic r1en, input int r1, input logic r2en,
                              input int r2, input logic wen, input int wa, input logic ld);
    ins_t i;
    i.v = v; i.r1en = r1en; i.r1 = AS'(r1); i.r2en = r2en; i.r2 = AS'(r2);
    i.wen = wen; i.wa = AS'(wa); i.ld = ld;
    return i;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = '0;
    m_s1 = 0; m_s2 = 0; m_sc = 0; m_fc = 0;
  endtask

  // One clock cycle: present an ID instruction, predict the outputs, advance the model.
  task automatic step(input ins_t in, input logic taken, output logic st);
    exp_t       e;
    logic       hz, e1, e2;
    logic [1:0] n1, n2;
    @(posedge clk);
    #1;
    hif.id_valid  = in.v;
    hif.id_ren1   = in.r1en;
    hif.id_raddr1 = in.r1;
    hif.id_ren2   = in.r2en;
    hif.id_raddr2 = in.r2;
    hif.id_wen    = in.wen;
    hif.id_waddr  = in.wa;
    hif.id_load   = in.ld;
    hif.ex_taken  = taken;
    e1 = in.v & in.r1en;
    e2 = in.v & in.r2en;
`ifdef FORWARD_EN
    hz = hit(e1, in.r1, 2) | hit(e2, in.r2, 2) |
         (hist[0].ld & (hit(e1, in.r1, 0) | hit(e2, in.r2, 0)));
    n1 = fsel(e1, in.r1);
    n2 = fsel(e2, in.r2);
`else
    hz = 1'b0;
    for (int k = 0; k < 3; k++) hz = hz | hit(e1, in.r1, k) | hit(e2, in.r2, k);
    n1 = 2'd0;
    n2 = 2'd0;
`endif
    e.flush  = taken;
    e.stall  = hz & ~taken;
    e.bubble = e.stall | e.flush;
    e.s1 = m_s1; e.s2 = m_s2; e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    if (e.stall && m_sc != {CW{1'b1}}) m_sc = m_sc + 1'b1;
    if (e.flush && m_fc != {CW{1'b1}}) m_fc = m_fc + 1'b1;
    m_s1 = e.bubble ? 2'd0 : n1;
    m_s2 = e.bubble ? 2'd0 : n2;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = e.bubble ? ins_t'('0) : in;
    st = e.stall;
  endtask

  // Keep re-presenting the instruction while it is held by a stall.
  task automatic issue(input ins_t in);
    logic st;
    int   n;
    n = 0;
    do begin
      step(in, 1'b0, st);
      n++;
    end while (st && n < 8);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue(ins_t'('0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stall"},  hif.stall,       0);
    chk({tag, "_flush"},  hif.flush,       0);
    chk({tag, "_bubble"}, hif.bubble,      0);
    chk({tag, "_sel1"},   hif.ex_fwd_sel1, 0);
    chk({tag, "_sel2"},   hif.ex_fwd_sel2, 0);
    chk({tag, "_scnt"},   hif.stall_cnt,   0);
    chk({tag, "_fcnt"},   hif.flush_cnt,   0);
  endtask

  // Asserts reset between clock edges with a branch pending, checks outputs immediately.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    hif.ex_taken = 1'b1;
    rst = 1'b0;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs({tag, "_held"});
    @(negedge clk);
    hif.ex_taken = 1'b0;
    hif.id_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    sb.delete();
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall",     hif.stall,       e.stall);
        chk("flush",     hif.flush,       e.flush);
        chk("bubble",    hif.bubble,      e.bubble);
        chk("fwd_sel1",  hif.ex_fwd_sel1, e.s1);
        chk("fwd_sel2",  hif.ex_fwd_sel2, e.s2);
        chk("stall_cnt", hif.stall_cnt,   e.sc);
        chk("flush_cnt", hif.flush_cnt,   e.fc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t cur;
    logic st, prev_st, prev_fl, tk;
    rst = 1'b0;
    hif.id_valid = 0; hif.id_ren1 = 0; hif.id_raddr1 = 0; hif.id_ren2 = 0;
    hif.id_raddr2 = 0; hif.id_wen = 0; hif.id_waddr = 0; hif.id_load = 0;
    hif.ex_taken = 0;
    model_reset();
    do_reset("por");

    // add r1 ; add r2,r1,r3
    issue(mk(1, 1, 2, 1, 3, 1, 1, 0));
    issue(mk(1, 1, 1, 1, 3, 1, 2, 0));
    nops(3);
    // load r4 ; sub r5,r4,r6
    issue(mk(1, 1, 8, 0, 0, 1, 4, 1));
    issue(mk(1, 1, 4, 1, 6, 1, 5, 0));
    nops(3);
    // writer r7, two unrelated, reader r7
    issue(mk(1, 1, 1, 0, 0, 1, 7, 0));
    issue(mk(1, 1, 10, 0, 0, 1, 8, 0));
    issue(mk(1, 1, 10, 0, 0, 1, 9, 0));
    issue(mk(1, 0, 0, 1, 7, 1, 11, 0));
    nops(3);
    // taken branch while ID holds a load-use consumer
    issue(mk(1, 1, 8, 0, 0, 1, 4, 1));
    step(mk(1, 1, 4, 0, 0, 1, 5, 0), 1'b1, st);
    issue(ins_t'('0));
    issue(mk(1, 1, 4, 0, 0, 1, 6, 0));
    nops(3);
    // r0 as writer and reader
    issue(mk(1, 1, 1, 0, 0, 1, 0, 0));
    issue(mk(1, 1, 0, 1, 0, 1, 2, 0));
    nops(3);

    // Random traffic on a small register window to keep hazards frequent.
    prev_st = 0;
    prev_fl = 0;
    cur = '0;
    for (int i = 0; i < 500; i++) begin
      if (!prev_st) begin
        if (prev_fl) cur = '0;
        else cur = mk($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 3),
                      $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      end
      tk = ($urandom_range(0, 9) == 0);
      step(cur, tk, st);
      prev_st = st;
      prev_fl = tk;
    end

    // Guarantee saturation of the stall counter with repeated load-use pairs.
    for (int i = 0; i < 20; i++) begin
      issue(mk(1, 1, 9, 0, 0, 1, 3, 1));
      issue(mk(1, 1, 3, 0, 0, 1, 5, 0));
    end
    nops(3);

    // Reset arriving in the middle of a stall.
    step(mk(1, 1, 9, 0, 0, 1, 4, 1), 1'b0, st);
    step(mk(1, 1, 4, 1, 4, 1, 5, 0), 1'b0, st);
    do_reset("midstall");
    nops(2);

    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline interlock and forwarding controller for the parametrised ID/EXE/MEM/WB datapath.
- Tracks every in-flight register writer in an internal shadow pipeline of NSTAGE entries (EXE, MEM, WB).
- Raises stall on unresolvable RAW hazards and flush on taken branches.
- Emits registered forwarding selects aligned with the instruction in EXE, plus saturating stall/flush statistics.

Parameters:
- ASIZE, 4, register address width.
- NSTAGE, 3, shadow entries after ID; entry 0 = EXE, 1 = MEM, 2 = WB. Fixed minimum 3.
- CNT_W, 16, width of statistic counters.
- ZERO_REG, 1, when 1 register 0 is hard-wired and never creates a hazard.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_ren1  in  1  ID reads raddr1.
- id_raddr1  in  ASIZE  ID source 1.
- id_ren2  in  1  ID reads raddr2.
- id_raddr2  in  ASIZE  ID source 2.
- id_wen  in  1  ID instruction writes the register file.
- id_waddr  in  ASIZE  ID destination.
- id_load  in  1  ID instruction is a load (memtoreg).
- ex_taken  in  1  branch in EXE resolved taken.
- stall  out  1  hold PC and IF/ID.
- flush  out  1  kill IF/ID contents.
- bubble  out  1  load zeroed control into ID/EXE this edge.
- ex_fwd_sel1  out  2  EXE operand-1 source: 0 = ID/EXE rdata1, 1 = EXE/MEM aluout, 2 = MEM/WB wdata.
- ex_fwd_sel2  out  2  same for operand 2 (ignored by the datapath when alusrc selects imm).
- stall_cnt  out  CNT_W  cycles with stall=1.
- flush_cnt  out  CNT_W  cycles with flush=1.

Behaviour:
- Reset (rst=0, async): all shadow entries invalid; stall=0, flush=0, bubble=0; fwd_sel=0; counters=0.
- Shadow entry fields: valid, wen, waddr, load.
- Every clk edge: entry[k] <= entry[k-1] for k>=1.
- entry[0] <= the ID fields, or invalid when bubble=1.
- Match(src,k) = ren & entry[k].valid & entry[k].wen & (waddr==src) & !(ZERO_REG & src==0).
- Regfile has no write-through; a match against entry[2] (WB) always stalls 1 cycle, and ID re-reads afterwards.
- Load-use: a match against entry[0] with entry[0].load=1 stalls 1 cycle.
  - After the stall the writer sits in entry[1], so the operand forwards with sel=2.
- With forwarding, non-stalling matches:
  - entry[0] match gives sel 1.
  - entry[1] match gives sel 2.
  - Youngest match wins (entry[0] over entry[1]).
  - Sel is computed from ID and registered, so it is valid while that instruction is in EXE.
- When stall=1 or flush=1 the registered sel loads 0.
- flush = ex_taken (combinational). bubble = stall | flush.
- flush has priority: when ex_taken=1, stall is forced 0, because the hazarding ID instruction is discarded.
- id_valid=0: no hazard, stall=0; entry[0] is loaded invalid.
- Counters increment when their signal is 1 and saturate at all-ones, with no wrap.
- Reset mid-stall: all outputs return to reset values immediately and asynchronously.

Optional Feature:
- FORWARD_EN defined: forwarding behaviour as above.
- FORWARD_EN undefined:
  - Any match against any entry 0..NSTAGE-1 stalls; stall repeats each cycle until no entry matches.
  - ex_fwd_sel1/2 are tied 0.
  - The load-use rule is subsumed.

Decomposition:
- Shared package/define file holds:
  - FWD_RF=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2;
  - the shadow-entry field layout (valid, wen, load, waddr) as packed width constants.
- Natural sub-module: hazard_sat_counter (CNT_W, inc, saturating, async active-low clear), instantiated twice.

Test Plan:
- `add r1` then `add r2,r1,r3` back-to-back (FORWARD_EN) -> stall never 1; ex_fwd_sel1=1 in the consumer's EXE cycle.
- `load r4` then `sub r5,r4,r6` -> stall=1 and bubble=1 for exactly 1 cycle, stall_cnt=1; then ex_fwd_sel1=2.
- Writer r7, two unrelated instructions, then reader r7 -> WB match gives stall=1 for 1 cycle, then sel=0.
- Same as test 1 without FORWARD_EN -> stall=1 for 3 consecutive cycles; sel stays 0.
- ex_taken=1 while ID has a load-use hazard -> flush=1, stall=0, bubble=1; flush_cnt=1; entry[0] invalid next cycle.
- Writer and reader both using r0 with ZERO_REG=1 -> no stall, sel=0. Then force stall for 2^CNT_W+3 cycles (CNT_W=4 build) -> stall_cnt=15; assert rst=0 mid-stall -> all outputs 0 without waiting for a clock edge.
